pattern_sequencer: RTL and testbench

//  Multi-channel, tick-paced bit-pattern player driving LEDs/pins (Morse, status codes).
//  One shared prescaler generates the bit tick. Each channel holds its own pattern, length and mode.
//  A valid/ready load port reprograms any channel at runtime. Sits between board-level top and pins.

---
 rtl/pattern_seq_pkg.sv | 20 ++
 rtl/pattern_channel.sv | 96 +++++++++
 rtl/pattern_sequencer.sv | 85 ++++++++
 tb/tb_pattern_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_seq_pkg.sv
// Shared types for the pattern sequencer: channel state encoding, play modes and
// a width helper.
package pattern_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_PLAY  = 2'd2
   } ch_state_e;

   localparam logic MODE_LOOP    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

   // Bit width needed to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      if (n > 1) return $clog2(n);
      return 1;
   endfunction

endpackage

// File: rtl/pattern_channel.sv
// One sequencer channel: holds its pattern, steps through it on each shared tick,
// and reports busy / one-shot completion.
module pattern_channel
   import pattern_seq_pkg::*;
#(
   parameter int unsigned MAX_LEN = 128,
   parameter int unsigned IDX_W   = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               load,
   input  logic [MAX_LEN-1:0] load_pattern,
   input  logic [IDX_W-1:0]   load_last,
   input  logic               load_mode,
   input  logic               stop,
   output logic               led,
   output logic               busy,
   output logic               done
);

   ch_state_e            state_q, state_d;
   logic [MAX_LEN-1:0]   pattern_q, pattern_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [IDX_W-1:0]     index_q, index_d;
   logic                 mode_q, mode_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   // Priority: load, then stop, then tick-driven stepping.
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      last_d    = last_q;
      index_d   = index_q;
      mode_d    = mode_q;
      done_d    = 1'b0;

      if (load) begin
         pattern_d = load_pattern;
         last_d    = load_last;
         mode_d    = load_mode;
         index_d   = '0;
         state_d   = ST_ARMED;
      end else if (stop) begin
         index_d = '0;
         state_d = ST_IDLE;
      end else if (tick) begin
         case (state_q)
            ST_ARMED: begin
               index_d = '0;
               state_d = ST_PLAY;
            end
            ST_PLAY: begin
               if (index_q < last_q) begin
                  index_d = index_q + IDX_W'(1);
               end else if (mode_q == MODE_ONESHOT) begin
                  index_d = '0;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  index_d = '0;
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pattern_q <= '0;
         last_q    <= '0;
         index_q   <= '0;
         mode_q    <= MODE_LOOP;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         last_q    <= last_d;
         index_q   <= index_d;
         mode_q    <= mode_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign led  = (state_q == ST_PLAY) & pattern_q[index_q];
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Multi-channel tick-paced bit-pattern player: shared prescaler, valid/ready load
// port with out-of-range detection, and one pattern_channel per output.
module pattern_sequencer
   import pattern_seq_pkg::*;
#(
   parameter int unsigned TICK_RATE = 5_000_000,
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned MAX_LEN   = 128,
   parameter int unsigned CH_W      = clog2_min1(CHANNELS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_valid,
   output logic                       load_ready,
   input  logic [CH_W-1:0]            load_chan,
   input  logic [MAX_LEN-1:0]         load_pattern,
   input  logic [$clog2(MAX_LEN)-1:0] load_last,
   input  logic                       load_oneshot,
   input  logic [CHANNELS-1:0]        stop,
   output logic [CHANNELS-1:0]        led,
   output logic [CHANNELS-1:0]        busy,
   output logic [CHANNELS-1:0]        done,
   output logic                       load_err
);

   localparam int unsigned IDX_W = $clog2(MAX_LEN);
   localparam int unsigned CNT_W = clog2_min1(TICK_RATE);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                load_ready_q;
   logic                load_err_q, load_err_d;
   logic                tick_c;
   logic                accept_c;
   logic [CHANNELS-1:0] load_vec_c;

   // Free-running prescaler; tick marks the last count of each bit period.
   always_comb begin
      tick_c = (cnt_q == CNT_W'(TICK_RATE - 1));
      cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
   end

   always_comb begin
      accept_c   = load_valid & load_ready_q;
      load_err_d = accept_c && (32'(load_chan) >= CHANNELS);
      load_vec_c = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         load_vec_c[i] = accept_c && (32'(load_chan) == i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         load_ready_q <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         load_ready_q <= 1'b1;
         load_err_q   <= load_err_d;
      end
   end

   assign load_ready = load_ready_q;
   assign load_err   = load_err_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      pattern_channel #(
         .MAX_LEN (MAX_LEN),
         .IDX_W   (IDX_W)
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .tick         (tick_c),
         .load         (load_vec_c[g]),
         .load_pattern (load_pattern),
         .load_last    (load_last),
         .load_mode    (load_oneshot),
         .stop         (stop[g]),
         .led          (led[g]),
         .busy         (busy[g]),
         .done         (done[g])
      );
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench: directed scenarios then random traffic, all checked each cycle
// against a tick-counting reference model of the sequencer.
module tb_pattern_sequencer;

   localparam int unsigned TR  = 4;
   localparam int unsigned NCH = 2;
   localparam int unsigned ML  = 8;
   localparam int unsigned CW  = 2;
   localparam int unsigned IW  = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           load_valid;
   logic           load_ready;
   logic [CW-1:0]  load_chan;
   logic [ML-1:0]  load_pattern;
   logic [IW-1:0]  load_last;
   logic           load_oneshot;
   logic [NCH-1:0] stop;
   logic [NCH-1:0] led;
   logic [NCH-1:0] busy;
   logic [NCH-1:0] done;
   logic           load_err;

   always #5 clk = ~clk;

   pattern_sequencer #(
      .TICK_RATE (TR),
      .CHANNELS  (NCH),
      .MAX_LEN   (ML),
      .CH_W      (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_chan    (load_chan),
      .load_pattern (load_pattern),
      .load_last    (load_last),
      .load_oneshot (load_oneshot),
      .stop         (stop),
      .led          (led),
      .busy         (busy),
      .done         (done),
      .load_err     (load_err)
   );

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a channel is described by how many ticks it has seen since
   // its last load; the visible bit follows directly from that count.
   bit          m_act  [NCH];
   int          m_k    [NCH];
   logic [ML-1:0] m_pat [NCH];
   int          m_len  [NCH];
   bit          m_one  [NCH];
   bit          m_done [NCH];
   bit          m_err = 0;
   bit          m_rdy = 0;
   int          m_cyc = 0;
   int          done1_seen = 0;

   initial begin
      for (int c = 0; c < NCH; c++) begin
         m_act[c] = 0; m_k[c] = 0; m_pat[c] = '0; m_len[c] = 1; m_one[c] = 0; m_done[c] = 0;
      end
   end

   task automatic model_edge();
      bit tick;
      bit acc;
      tick  = ((m_cyc % TR) == TR - 1);
      m_cyc = m_cyc + 1;
      acc   = load_valid && m_rdy;
      m_err = acc && (int'(load_chan) >= NCH);
      for (int c = 0; c < NCH; c++) begin
         m_done[c] = 0;
         if (acc && int'(load_chan) == c) begin
            m_act[c] = 1;
            m_k[c]   = 0;
            m_pat[c] = load_pattern;
            m_len[c] = int'(load_last) + 1;
            m_one[c] = load_oneshot;
         end else if (stop[c]) begin
            m_act[c] = 0;
         end else if (tick && m_act[c]) begin
            m_k[c]++;
            if (m_one[c] && m_k[c] > m_len[c]) begin
               m_act[c]  = 0;
               m_done[c] = 1;
            end
         end
      end
      m_rdy = 1;
   endtask

   task automatic compare();
      logic exp_led;
      for (int c = 0; c < NCH; c++) begin
         exp_led = 1'b0;
         if (m_act[c] && m_k[c] >= 1) exp_led = m_pat[c][(m_k[c] - 1) % m_len[c]];
         chk($sformatf("led%0d", c),  32'(led[c]),  32'(exp_led));
         chk($sformatf("busy%0d", c), 32'(busy[c]), 32'(m_act[c]));
         chk($sformatf("done%0d", c), 32'(done[c]), 32'(m_done[c]));
      end
      chk("load_err",   32'(load_err),   32'(m_err));
      chk("load_ready", 32'(load_ready), 32'(m_rdy));
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #1;
         compare();
         if (done[1]) done1_seen++;
      end
   endtask

   task automatic idle_inputs();
      load_valid   = 1'b0;
      load_chan    = '0;
      load_pattern = '0;
      load_last    = '0;
      load_oneshot = 1'b0;
      stop         = '0;
   endtask

   task automatic do_load(input int ch, input logic [ML-1:0] pat, input int last, input bit one);
      load_valid   = 1'b1;
      load_chan    = CW'(ch);
      load_pattern = pat;
      load_last    = IW'(last);
      load_oneshot = one;
   endtask

   initial begin
      idle_inputs();
      #22 rst_n = 1'b1;
      #1;
      compare();
      step(1);

      // Looping 4-bit pattern on ch0.
      do_load(0, 8'b0000_1101, 3, 1'b0);
      step(1);
      idle_inputs();
      step(40);

      // Three-bit one-shot on ch1.
      done1_seen = 0;
      do_load(1, 8'b0000_0110, 2, 1'b1);
      step(1);
      idle_inputs();
      step(24);
      chk("ch1_done_count", 32'(done1_seen), 32'd1);

      // Single-cycle stop while ch0 plays.
      stop = 2'b01;
      step(1);
      idle_inputs();
      step(6);

      // Restart ch0, then stop and reload in the same cycle.
      do_load(0, 8'b1010_0011, 7, 1'b0);
      step(1);
      idle_inputs();
      step(9);
      do_load(0, 8'b0101_1001, 4, 1'b0);
      stop = 2'b01;
      step(1);
      idle_inputs();
      step(30);

      // Out-of-range channel.
      do_load(2, 8'hFF, 7, 1'b0);
      step(1);
      idle_inputs();
      step(3);
      do_load(3, 8'hAA, 1, 1'b1);
      step(1);
      idle_inputs();
      step(3);

      // Single-bit one-shot and single-bit loop.
      do_load(0, 8'b0000_0001, 0, 1'b1);
      step(1);
      idle_inputs();
      step(12);
      do_load(1, 8'b1111_1111, 0, 1'b0);
      step(1);
      idle_inputs();
      step(12);

      // Preempt a playing one-shot.
      do_load(0, 8'b0000_1011, 3, 1'b1);
      step(1);
      idle_inputs();
      step(9);
      do_load(0, 8'b0000_0101, 2, 1'b1);
      step(1);
      idle_inputs();
      step(20);

      // Random traffic.
      repeat (2000) begin
         load_valid   = ($urandom_range(0, 7) == 0);
         load_chan    = CW'($urandom_range(0, 3));
         load_pattern = ML'($urandom);
         load_last    = IW'($urandom_range(0, ML - 1));
         load_oneshot = 1'($urandom_range(0, 1));
         for (int c = 0; c < NCH; c++) stop[c] = ($urandom_range(0, 39) == 0);
         step(1);
      end
      idle_inputs();
      step(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
